alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue/writeback front end for the DLX integer ALU.
- Accepts one 32-bit DLX R-type or I-type ALU instruction per cycle over a valid/ready handshake.
- Decodes it, reads operands from the register file, and drives the ALU's I/EX/op1/op2 inputs.
- Collects the registered ALU result one cycle later and writes it back to the register file; stalls or forwards on read-after-write hazards.

Parameters:
FORWARD, 1, 1 = forward the ALU-stage result to the decoding instruction; 0 = stall until the register-file write completes.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word present
instr_ready  out  1  block can accept instruction this cycle (combinational)
instr  in  32  DLX instruction word
rs1_addr  out  5  register-file read address A = instr[25:21]
rs1_data  in  32  register-file read data A (combinational read)
rs2_addr  out  5  register-file read address B = instr[20:16]
rs2_data  in  32  register-file read data B
alu_I  out  4  ALU operation code
alu_EX  out  1  ALU capture enable, one cycle per issued instruction
alu_op1  out  32  ALU operand 1
alu_op2  out  32  ALU operand 2
alu_res1  in  32  registered ALU result
alu_carry  in  1  registered ALU carry (observed, not used)
alu_z  in  1  registered ALU zero flag (observed, not used)
wb_en  out  1  register-file write enable
wb_addr  out  5  write register
wb_data  out  32  write data (= alu_res1)
illegal  out  1  one-cycle pulse: accepted word was not a supported opcode

Behaviour:
- Reset (async, rst_n=0): stage valid bits v1 and v2 = 0; alu_EX=0, wb_en=0, illegal=0, alu_I=0, alu_op1=alu_op2=0, wb_addr=0. Reset mid-flight discards in-flight instructions; no write back after release.
- Decode, R-type (opcode instr[31:26]=0x00), keyed on func=instr[5:0]:
  - 0x20 ADD→1, 0x22 SUB→2, 0x24 AND→3, 0x25 OR→4, 0x26 XOR→5.
  - 0x04 SLL→6, 0x06 SRL→7, 0x07 SRA→14.
  - 0x28 SEQ→10, 0x2C SLE→11, 0x2A SLT→12, 0x29 SNE→13.
  - rd = instr[15:11]; op1 = A; op2 = B.
- Decode, I-type (opcode selects the operation):
  - 0x08 ADDI→1, 0x0A SUBI→2, 0x0C ANDI→3, 0x0D ORI→4, 0x0E XORI→5.
  - 0x14 SLLI→6, 0x16 SRLI→7, 0x17 SRAI→14.
  - 0x18 SEQI→10, 0x1C SLEI→11, 0x1A SLTI→12, 0x19 SNEI→13.
  - rd = instr[20:16]; op1 = A.
  - op2 = imm16 zero-extended for ANDI/ORI/XORI, sign-extended for all others.
- Any other opcode/func is illegal:
  - The word is accepted.
  - illegal=1 in the following cycle.
  - No alu_EX, no writeback.
- Pipeline:
  - Cycle N (accept): decode and register alu_I/op1/op2/rd; set v1.
  - Cycle N+1: alu_EX=1 (ALU captures at end of N+1); v1 advances to v2.
  - Cycle N+2: wb_en=1, wb_addr=rd, wb_data=alu_res1.
  - Issue-to-writeback latency is 2 cycles; throughput is 1 instruction/cycle.
  - alu_EX is high in consecutive cycles for back-to-back issue.
- rd = 0: the instruction is issued (alu_EX pulses) but wb_en stays 0. r0 is never a hazard source.
- Operand A and B hazards are resolved independently; for each operand:
  - If the read address equals the v1 stage rd (nonzero): instr_ready=0, 1-cycle stall.
  - Else, if it equals the v2 stage rd (nonzero): FORWARD=1 uses alu_res1; FORWARD=0 sets instr_ready=0 for one cycle.
  - Register-file bypass of same-cycle writes is not relied upon.
- An I-type word ignores the rs2 hazard.
- instr_ready is low only for hazard stalls or while rst_n=0.
- instr and instr_valid must remain stable while valid is high and ready is low.
- The ALU's comparison semantics are unsigned; decode does not alter operands to change this.

Test Plan:
1. ADD r3,r1,r2 with r1=5, r2=7 (instr 0x00221820) → next cycle alu_I=1, op1=5, op2=7, alu_EX=1; two cycles after accept, wb_en=1, wb_addr=3, wb_data=12.
2. ADDI r4,r0,0xFFFF → op2=0xFFFFFFFF. ORI r4,r0,0xFFFF → op2=0x0000FFFF. SRAI with imm=3 → alu_I=14.
3. Back-to-back ADDI r1,r0,1 then ADD r2,r1,r1 → instr_ready=0 for 1 cycle; with FORWARD=1, second op1=op2=1 taken from alu_res1, result wb_data=2. Repeat with FORWARD=0 → 2 stall cycles, same result.
4. ADD r0,r1,r2 then ADD r5,r0,r0 → no stall; first instruction produces alu_EX but no wb_en.
5. instr=0xFC000000 → illegal=1 for one cycle, alu_EX=0, wb_en=0; next legal instruction is accepted normally.
6. Assert rst_n=0 for 1 cycle, asynchronously, one cycle after issuing ADD r6 → wb_en stays 0; alu_EX=0 immediately; instr_ready=1 after release.

Source files
------------

// File: rtl/alu_issue.sv
// Issue/writeback front end for the DLX integer ALU.
// Decodes one R/I-type word per cycle, drives the ALU and writes its registered result back.
module alu_issue #(
    parameter bit FORWARD = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rs1_addr,
    input  logic [31:0] rs1_data,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs2_data,
    output logic [3:0]  alu_I,
    output logic        alu_EX,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_res1,
    input  logic        alu_carry,
    input  logic        alu_z,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        is_r;
    logic        zext;
    logic [3:0]  dec_op;
    logic        legal;
    logic [4:0]  rd_dec;
    logic [31:0] imm;
    logic        v1;
    logic [4:0]  rd1;
    logic        a_v1;
    logic        a_v2;
    logic        b_v1;
    logic        b_v2;
    logic        stall;
    logic        accept;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        unused_flags;

    assign opcode   = instr[31:26];
    assign func     = instr[5:0];
    assign is_r     = (opcode == 6'h00);
    assign rs1_addr = instr[25:21];
    assign rs2_addr = instr[20:16];

    always_comb begin
        dec_op = 4'd0;
        zext   = 1'b0;
        if (is_r) begin
            case (func)
                6'h20:   dec_op = 4'd1;
                6'h22:   dec_op = 4'd2;
                6'h24:   dec_op = 4'd3;
                6'h25:   dec_op = 4'd4;
                6'h26:   dec_op = 4'd5;
                6'h04:   dec_op = 4'd6;
                6'h06:   dec_op = 4'd7;
                6'h07:   dec_op = 4'd14;
                6'h28:   dec_op = 4'd10;
                6'h2C:   dec_op = 4'd11;
                6'h2A:   dec_op = 4'd12;
                6'h29:   dec_op = 4'd13;
                default: dec_op = 4'd0;
            endcase
        end else begin
            case (opcode)
                6'h08:   dec_op = 4'd1;
                6'h0A:   dec_op = 4'd2;
                6'h0C: begin
                    dec_op = 4'd3;
                    zext   = 1'b1;
                end
                6'h0D: begin
                    dec_op = 4'd4;
                    zext   = 1'b1;
                end
                6'h0E: begin
                    dec_op = 4'd5;
                    zext   = 1'b1;
                end
                6'h14:   dec_op = 4'd6;
                6'h16:   dec_op = 4'd7;
                6'h17:   dec_op = 4'd14;
                6'h18:   dec_op = 4'd10;
                6'h1C:   dec_op = 4'd11;
                6'h1A:   dec_op = 4'd12;
                6'h19:   dec_op = 4'd13;
                default: dec_op = 4'd0;
            endcase
        end
    end

    assign legal  = (dec_op != 4'd0);
    assign rd_dec = is_r ? instr[15:11] : instr[20:16];
    assign imm    = zext ? {16'h0000, instr[15:0]} : {{16{instr[15]}}, instr[15:0]};

    // wb_en already implies a nonzero destination, so it doubles as the v2 stage valid.
    assign a_v1 = v1 && (rd1 != 5'd0) && (rd1 == rs1_addr);
    assign a_v2 = wb_en && (wb_addr == rs1_addr);
    assign b_v1 = is_r && v1 && (rd1 != 5'd0) && (rd1 == rs2_addr);
    assign b_v2 = is_r && wb_en && (wb_addr == rs2_addr);

    assign stall       = instr_valid && legal &&
                         (a_v1 || b_v1 || (!FORWARD && (a_v2 || b_v2)));
    assign instr_ready = rst_n && !stall;
    assign accept      = instr_valid && instr_ready;

    assign op_a = (FORWARD && a_v2) ? alu_res1 : rs1_data;
    assign op_b = (FORWARD && b_v2) ? alu_res1 : rs2_data;

    assign alu_EX       = v1;
    assign wb_data      = alu_res1;
    assign unused_flags = alu_carry ^ alu_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            rd1     <= 5'd0;
            alu_I   <= 4'd0;
            alu_op1 <= 32'd0;
            alu_op2 <= 32'd0;
            wb_en   <= 1'b0;
            wb_addr <= 5'd0;
            illegal <= 1'b0;
        end else begin
            v1      <= accept && legal;
            illegal <= accept && !legal;
            wb_en   <= v1 && (rd1 != 5'd0);
            wb_addr <= rd1;
            if (accept && legal) begin
                alu_I   <= dec_op;
                alu_op1 <= op_a;
                alu_op2 <= is_r ? op_b : imm;
                rd1     <= rd_dec;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: both FORWARD settings against an architectural
// (program-order) register model with a cycle-slot expectation schedule.
module tb_alu_issue;

    localparam logic [5:0] R_FUNCS [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04,
                                            6'h06, 6'h07, 6'h28, 6'h2C, 6'h2A, 6'h29};
    localparam logic [5:0] I_OPS   [12] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h14,
                                            6'h16, 6'h17, 6'h18, 6'h1C, 6'h1A, 6'h19};
    localparam logic [3:0] CODES   [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                            4'd7, 4'd14, 4'd10, 4'd11, 4'd12, 4'd13};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        rf_clear;
    logic        instr_valid [2];
    logic [31:0] instr       [2];
    logic        instr_ready [2];
    logic [4:0]  rs1_addr    [2];
    logic [4:0]  rs2_addr    [2];
    logic [31:0] rs1_data    [2];
    logic [31:0] rs2_data    [2];
    logic [3:0]  alu_I       [2];
    logic        alu_EX      [2];
    logic [31:0] alu_op1     [2];
    logic [31:0] alu_op2     [2];
    logic [31:0] alu_res1    [2];
    logic        alu_carry   [2];
    logic        alu_z       [2];
    logic        wb_en       [2];
    logic [4:0]  wb_addr     [2];
    logic [31:0] wb_data     [2];
    logic        illegal     [2];

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd1:    alu_fn = a + b;
            4'd2:    alu_fn = a - b;
            4'd3:    alu_fn = a & b;
            4'd4:    alu_fn = a | b;
            4'd5:    alu_fn = a ^ b;
            4'd6:    alu_fn = a << b[4:0];
            4'd7:    alu_fn = a >> b[4:0];
            4'd14:   alu_fn = $signed(a) >>> b[4:0];
            4'd10:   alu_fn = {31'd0, a == b};
            4'd11:   alu_fn = {31'd0, a <= b};
            4'd12:   alu_fn = {31'd0, a < b};
            4'd13:   alu_fn = {31'd0, a != b};
            default: alu_fn = 32'd0;
        endcase
    endfunction

    // Instance 0 forwards, instance 1 stalls; each has its own register file and ALU.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] rf [32];
        logic [31:0] res_q;

        alu_issue #(.FORWARD(g == 0 ? 1'b1 : 1'b0)) dut (
            .clk(clk), .rst_n(rst_n),
            .instr_valid(instr_valid[g]), .instr_ready(instr_ready[g]), .instr(instr[g]),
            .rs1_addr(rs1_addr[g]), .rs1_data(rs1_data[g]),
            .rs2_addr(rs2_addr[g]), .rs2_data(rs2_data[g]),
            .alu_I(alu_I[g]), .alu_EX(alu_EX[g]), .alu_op1(alu_op1[g]), .alu_op2(alu_op2[g]),
            .alu_res1(alu_res1[g]), .alu_carry(alu_carry[g]), .alu_z(alu_z[g]),
            .wb_en(wb_en[g]), .wb_addr(wb_addr[g]), .wb_data(wb_data[g]),
            .illegal(illegal[g])
        );

        assign rs1_data[g]  = rf[rs1_addr[g]];
        assign rs2_data[g]  = rf[rs2_addr[g]];
        assign alu_res1[g]  = res_q;
        assign alu_carry[g] = 1'b0;
        assign alu_z[g]     = (res_q == 32'd0);

        always @(posedge clk) begin
            if (rf_clear) begin
                for (int r = 0; r < 32; r++) rf[r] <= 32'd0;
            end else if (wb_en[g] && wb_addr[g] != 5'd0) begin
                rf[wb_addr[g]] <= wb_data[g];
            end
            if (alu_EX[g]) res_q <= alu_fn(alu_I[g], alu_op1[g], alu_op2[g]);
        end
    end

    int          sel;
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [31:0] ref_regs [32];
    int          last_acc [32];
    bit          ex_v  [4];
    logic [3:0]  ex_i  [4];
    logic [31:0] ex_a  [4];
    logic [31:0] ex_b  [4];
    bit          wb_v  [4];
    logic [4:0]  wb_a  [4];
    logic [31:0] wb_d  [4];
    bit          ill_v [4];

    function automatic logic [31:0] rtype(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd, input logic [5:0] fn);
        rtype = {6'h00, rs1, rs2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [15:0] im);
        itype = {op, rs1, rd, im};
    endfunction

    function automatic logic [3:0] code_of(input logic [31:0] w);
        code_of = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (w[31:26] == 6'h00 && w[5:0] == R_FUNCS[i]) code_of = CODES[i];
            if (w[31:26] != 6'h00 && w[31:26] == I_OPS[i]) code_of = CODES[i];
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            ex_v[i] = 1'b0;
            wb_v[i] = 1'b0;
            ill_v[i] = 1'b0;
        end
        for (int r = 0; r < 32; r++) last_acc[r] = -100;
        cyc = 0;
    endtask

    // One clock: check this cycle's registered outputs, present a word, check ready, schedule.
    task automatic step(input logic [31:0] word, input bit valid, output bit accepted,
                        output bit seen_ready);
        int s;
        bit exp_ready;
        bit r_type;
        logic [3:0] code;
        logic [4:0] ra, rb, rd;
        logic [31:0] a, b, res;
        @(negedge clk);
        s = cyc % 4;
        n_checks++;
        if (alu_EX[sel] !== ex_v[s]) begin
            n_fail++;
            $display("[TB] FAIL alu_EX fwd=%0d cyc=%0d got %b want %b", 1 - sel, cyc, alu_EX[sel], ex_v[s]);
        end
        if (ex_v[s]) begin
            n_checks++;
            if (alu_I[sel] !== ex_i[s] || alu_op1[sel] !== ex_a[s] || alu_op2[sel] !== ex_b[s]) begin
                n_fail++;
                $display("[TB] FAIL alu_inputs fwd=%0d cyc=%0d got I=%0d op1=%h op2=%h want I=%0d op1=%h op2=%h",
                         1 - sel, cyc, alu_I[sel], alu_op1[sel], alu_op2[sel], ex_i[s], ex_a[s], ex_b[s]);
            end
        end
        n_checks++;
        if (wb_en[sel] !== wb_v[s]) begin
            n_fail++;
            $display("[TB] FAIL wb_en fwd=%0d cyc=%0d got %b want %b", 1 - sel, cyc, wb_en[sel], wb_v[s]);
        end
        if (wb_v[s]) begin
            n_checks++;
            if (wb_addr[sel] !== wb_a[s] || wb_data[sel] !== wb_d[s]) begin
                n_fail++;
                $display("[TB] FAIL writeback fwd=%0d cyc=%0d got r%0d=%h want r%0d=%h",
                         1 - sel, cyc, wb_addr[sel], wb_data[sel], wb_a[s], wb_d[s]);
            end
        end
        n_checks++;
        if (illegal[sel] !== ill_v[s]) begin
            n_fail++;
            $display("[TB] FAIL illegal fwd=%0d cyc=%0d got %b want %b", 1 - sel, cyc, illegal[sel], ill_v[s]);
        end
        ex_v[s] = 1'b0;
        wb_v[s] = 1'b0;
        ill_v[s] = 1'b0;

        instr[sel] = word;
        instr_valid[sel] = valid;
        code   = code_of(word);
        r_type = (word[31:26] == 6'h00);
        ra     = word[25:21];
        rb     = word[20:16];
        rd     = r_type ? word[15:11] : word[20:16];

        // A source is unavailable while its latest producer issued one cycle ago,
        // or two cycles ago when results are not forwarded.
        exp_ready = 1'b1;
        if (valid && code != 4'd0) begin
            if (ra != 5'd0 && (cyc - last_acc[ra] == 1 || (sel == 1 && cyc - last_acc[ra] == 2)))
                exp_ready = 1'b0;
            if (r_type && rb != 5'd0 &&
                (cyc - last_acc[rb] == 1 || (sel == 1 && cyc - last_acc[rb] == 2)))
                exp_ready = 1'b0;
        end
        #1;
        seen_ready = instr_ready[sel];
        n_checks++;
        if (instr_ready[sel] !== exp_ready) begin
            n_fail++;
            $display("[TB] FAIL instr_ready fwd=%0d cyc=%0d word=%h got %b want %b",
                     1 - sel, cyc, word, instr_ready[sel], exp_ready);
        end

        accepted = valid && exp_ready;
        if (accepted) begin
            if (code == 4'd0) begin
                ill_v[(cyc + 1) % 4] = 1'b1;
            end else begin
                a = ref_regs[ra];
                if (r_type) b = ref_regs[rb];
                else if (word[31:26] inside {6'h0C, 6'h0D, 6'h0E}) b = {16'h0000, word[15:0]};
                else b = {{16{word[15]}}, word[15:0]};
                res = alu_fn(code, a, b);
                ex_v[(cyc + 1) % 4] = 1'b1;
                ex_i[(cyc + 1) % 4] = code;
                ex_a[(cyc + 1) % 4] = a;
                ex_b[(cyc + 1) % 4] = b;
                if (rd != 5'd0) begin
                    wb_v[(cyc + 2) % 4] = 1'b1;
                    wb_a[(cyc + 2) % 4] = rd;
                    wb_d[(cyc + 2) % 4] = res;
                    ref_regs[rd] = res;
                    last_acc[rd] = cyc;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [31:0] word, output int stalls);
        bit acc, rdy;
        int tries;
        tries  = 0;
        stalls = 0;
        do begin
            step(word, 1'b1, acc, rdy);
            if (!rdy) stalls++;
            tries++;
        end while (!acc && tries < 8);
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL issue_timeout word=%h got no acceptance in %0d cycles, want acceptance", word, tries);
        end
    endtask

    task automatic idle(input int n);
        bit acc, rdy;
        repeat (n) step(32'd0, 1'b0, acc, rdy);
    endtask

    task automatic test_reset();
        instr_valid[sel] = 1'b0;
        rst_n    = 1'b0;
        rf_clear = 1'b1;
        #1;
        n_checks++;
        if (alu_EX[sel] !== 1'b0 || wb_en[sel] !== 1'b0 || illegal[sel] !== 1'b0 ||
            alu_I[sel] !== 4'd0 || alu_op1[sel] !== 32'd0 || alu_op2[sel] !== 32'd0 ||
            wb_addr[sel] !== 5'd0 || instr_ready[sel] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state fwd=%0d got EX=%b wb=%b ill=%b I=%0d op1=%h op2=%h wa=%0d rdy=%b want all 0",
                     1 - sel, alu_EX[sel], wb_en[sel], illegal[sel], alu_I[sel], alu_op1[sel],
                     alu_op2[sel], wb_addr[sel], instr_ready[sel]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rf_clear = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_checks++;
        if (instr_ready[sel] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_reset fwd=%0d got %b want 1", 1 - sel, instr_ready[sel]);
        end
        for (int r = 0; r < 32; r++) ref_regs[r] = 32'd0;
        model_clear();
    endtask

    task automatic test_add();
        int st;
        issue(itype(6'h08, 5'd0, 5'd1, 16'd5), st);
        issue(itype(6'h08, 5'd0, 5'd2, 16'd7), st);
        idle(3);
        issue(32'h00221820, st);
        idle(3);
    endtask

    task automatic test_imm();
        int st;
        issue(itype(6'h08, 5'd0, 5'd4, 16'hFFFF), st);
        issue(itype(6'h0D, 5'd0, 5'd4, 16'hFFFF), st);
        issue(itype(6'h17, 5'd4, 5'd5, 16'd3), st);
        issue(itype(6'h1A, 5'd5, 5'd6, 16'h8000), st);
        idle(3);
    endtask

    task automatic test_back_to_back();
        int st;
        issue(itype(6'h08, 5'd0, 5'd1, 16'd1), st);
        issue(rtype(5'd1, 5'd1, 5'd2, 6'h20), st);
        n_checks++;
        if (st !== (sel == 0 ? 1 : 2)) begin
            n_fail++;
            $display("[TB] FAIL back_to_back_stalls fwd=%0d got %0d want %0d", 1 - sel, st, sel == 0 ? 1 : 2);
        end
        idle(3);
    endtask

    task automatic test_r0();
        int st;
        issue(rtype(5'd1, 5'd2, 5'd0, 6'h20), st);
        issue(rtype(5'd0, 5'd0, 5'd5, 6'h20), st);
        n_checks++;
        if (st !== 0) begin
            n_fail++;
            $display("[TB] FAIL r0_no_stall fwd=%0d got %0d stalls want 0", 1 - sel, st);
        end
        idle(3);
    endtask

    task automatic test_illegal();
        int st;
        issue(32'hFC000000, st);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h3F), st);
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), st);
        idle(3);
    endtask

    task automatic test_reset_midflight();
        int st;
        logic [31:0] old6;
        old6 = ref_regs[6];
        issue(rtype(5'd1, 5'd2, 5'd6, 6'h20), st);
        #2;
        n_checks++;
        if (alu_EX[sel] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ex_before_reset fwd=%0d got %b want 1", 1 - sel, alu_EX[sel]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (alu_EX[sel] !== 1'b0 || instr_ready[sel] !== 1'b0 || wb_en[sel] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL async_reset fwd=%0d got EX=%b rdy=%b wb=%b want 0 0 0",
                     1 - sel, alu_EX[sel], instr_ready[sel], wb_en[sel]);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (instr_ready[sel] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ready_after_release fwd=%0d got %b want 1", 1 - sel, instr_ready[sel]);
        end
        ref_regs[6] = old6;
        model_clear();
        idle(3);
        issue(rtype(5'd6, 5'd0, 5'd7, 6'h25), st);
        idle(3);
    endtask

    task automatic test_random();
        int st;
        int k;
        logic [31:0] w;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            k = int'($urandom_range(0, 11));
            case ($urandom_range(0, 9))
                0: w = {6'h3F, 26'($urandom)};
                1, 2, 3, 4:
                    w = {6'h00, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom), R_FUNCS[k]};
                default:
                    w = itype(I_OPS[k], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              16'($urandom));
            endcase
            issue(w, st);
        end
        idle(3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        rf_clear = 1'b1;
        for (int g = 0; g < 2; g++) begin
            instr_valid[g] = 1'b0;
            instr[g]       = 32'd0;
        end
        for (int k = 0; k < 2; k++) begin
            sel = k;
            $display("[TB] running instance with FORWARD=%0d", 1 - sel);
            test_reset();
            test_add();
            test_imm();
            test_back_to_back();
            test_r0();
            test_illegal();
            test_reset_midflight();
            test_random();
            instr_valid[sel] = 1'b0;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
